xor_gates: RTL and testbench
============================

# xor_gates

Two-input bitwise logic-gate unit. Its default function is XOR, and it can be switched to the other basic gate functions. It provides a zero-latency combinational result and a one-cycle registered copy. It is a leaf primitive used wherever datapath logic needs a selectable gate. With `op` tied to zero it behaves exactly as a plain XOR gate.

## Interface
Parameters:
- `WIDTH`, default 1: operand and result width in bits; legal range 1..64.

Ports:
- One clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- `clk` input 1: rising-edge clock; used only by the registered outputs.
- `rst` input 1: synchronous, active-high reset.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `op` input 3: function select; 3'b000 selects XOR.
- `y` output WIDTH: combinational result of `op` applied to `a` and `b`.
- `y_q` output WIDTH: `y` registered on `clk`.
- `y_q_par` output 1: XOR-reduction (parity) of `y_q`.

## Operation
- `op` encodings:
  - 000: XOR, `a ^ b`
  - 001: AND
  - 010: OR
  - 011: NAND
  - 100: NOR
  - 101: XNOR
  - 110: NOT A, `~a`; `b` is ignored
  - 111: BUF A, `a`; `b` is ignored
- The function is applied bitwise. No carries and no cross-bit interaction.
- XOR truth table per bit: 0,0→0; 0,1→1; 1,0→1; 1,1→0.
- `y` depends only on the current `a`, `b` and `op`. It has no state and is unaffected by `rst` and `clk`.
- Any X or Z on an input bit propagates to the matching `y` bit as in standard gate simulation. No masking.

## Timing
- `y`: zero-cycle latency, purely combinational. It must settle within the same delta/timestep as the input change.
- `y_q`: on each `clk` rising edge, `y_q <= rst ? 0 : y`. Latency is one cycle.
- `y_q_par`: combinational from `y_q`, so it changes with `y_q`.
- Reset values: `y_q` = 0 and `y_q_par` = 0. `y` is not reset.
- `rst` asserted mid-stream clears `y_q` at the next edge, whatever `y` is. Deasserting `rst` lets the following edge capture `y`.
- Input changes between edges do not affect `y_q` until the next edge. No glitch reaches `y_q`.
- An `op` change takes effect on `y` immediately and on `y_q` at the next edge.

## Structure
- Shared package `gates_pkg`:
  - 3-bit `op` enum: `OP_XOR`, `OP_AND`, `OP_OR`, `OP_NAND`, `OP_NOR`, `OP_XNOR`, `OP_NOTA`, `OP_BUFA`.
  - Constant `OP_DEFAULT = OP_XOR`.
- One natural sub-module, `gate_core`: a combinational WIDTH-parametric function mux producing `y`.
- The top level adds the output register and the parity reduction.

## Test plan
- XOR truth table, `WIDTH=1`, `op=000`, `a,b` stepped every 10 ns through 00, 01, 10, 11 → `y` = 0, 1, 1, 0 at each step.
- Op sweep, `WIDTH=1`, all four `a,b` combinations × 8 ops → `y` matches the encoding list. Examples: AND 1,1→1; NOR 0,0→1; NOTA a=1→0.
- Register latency: hold `op=000`; drive `a=1,b=0` just after an edge → `y`=1 immediately; `y_q`=1 only after the next edge; `y_q_par`=1 with it.
- Reset: `y_q`=1, assert `rst` for one edge → `y_q`=0 and `y_q_par`=0 after that edge while `y` stays 1. Deassert `rst` → `y_q`=1 at the next edge.
- Vector width, `WIDTH=8`, `op=000`, `a`=8'hA5, `b`=8'h0F → `y`=8'hAA; after one edge `y_q`=8'hAA and `y_q_par`=0. With `op=001` → `y`=8'h05.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared definitions for the selectable bitwise gate unit: function-select
// encoding and the default (XOR) function.
package gates_pkg;

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_BUFA = 3'b111
  } gate_op_e;

  localparam gate_op_e OP_DEFAULT = OP_XOR;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;

endpackage : gates_pkg

// File: rtl/gate_core.sv
// Combinational WIDTH-wide function mux: applies the selected two-input gate
// bitwise to a and b. Stateless; X/Z on operand bits propagate per bit.
module gate_core
  import gates_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  gate_op_e op_sel;

  assign op_sel = gate_op_e'(op);

  always_comb begin
    // NOTE: y gets a value before the case so no path through this block can
    // leave it unassigned, which would otherwise infer a latch.
    y = '0;
    case (op_sel)
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_BUFA: y = a;
      default: y = 'x;
    endcase
  end

endmodule : gate_core

// File: rtl/xor_gates.sv
// Selectable bitwise gate unit (XOR when op is 0) with a zero-latency result,
// a one-cycle registered copy and the parity of that registered copy.
module xor_gates
  import gates_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_q_par
);

  gate_core #(
    .WIDTH(WIDTH)
  ) u_gate_core (
    .a (a),
    .b (b),
    .op(op),
    .y (y)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values, keeping
    // simulation order-independent and matching the synthesized flop.
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

  // Parity follows the register, so it is clean of input glitches too.
  assign y_q_par = ^y_q;

endmodule : xor_gates

// File: tb/tb_xor_gates.sv
// Directed bench for xor_gates: 1-bit and 8-bit instances sharing clk/rst,
// compared against hand-computed expected values.
module tb_xor_gates;

  logic       clk;
  logic       rst;

  logic       a1, b1;
  logic [2:0] op1;
  logic       y1, y1_q, y1_q_par;

  logic [7:0] a8, b8;
  logic [2:0] op8;
  logic [7:0] y8, y8_q;
  logic       y8_q_par;

  int checks;
  int failures;

  xor_gates #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .a      (a1),
    .b      (b1),
    .op     (op1),
    .y      (y1),
    .y_q    (y1_q),
    .y_q_par(y1_q_par)
  );

  xor_gates #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .a      (a8),
    .b      (b8),
    .op     (op8),
    .y      (y8),
    .y_q    (y8_q),
    .y_q_par(y8_q_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth columns per op, bit index = {a,b}: bit0 is a=0,b=0 ... bit3 is a=1,b=1.
  logic [3:0] truth [8];

  initial begin
    truth[0] = 4'b0110; // XOR
    truth[1] = 4'b1000; // AND
    truth[2] = 4'b1110; // OR
    truth[3] = 4'b0111; // NAND
    truth[4] = 4'b0001; // NOR
    truth[5] = 4'b1001; // XNOR
    truth[6] = 4'b0011; // NOT A
    truth[7] = 4'b1100; // BUF A

    checks   = 0;
    failures = 0;

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b0; op1 = 3'b000;
    a8 = 8'hFF; b8 = 8'h00; op8 = 3'b000;
    tick();
    check("reset_y1_q", 64'(y1_q), 64'd0);
    check("reset_y1_par", 64'(y1_q_par), 64'd0);
    check("reset_y8_q", 64'(y8_q), 64'd0);
    check("reset_y8_par", 64'(y8_q_par), 64'd0);
    check("reset_y_unaffected", 64'(y1), 64'd1);
    rst = 1'b0;

    // XOR truth table, stepped every 10 ns.
    begin
      logic [3:0] xor_exp;
      xor_exp = 4'b0110;
      for (int i = 0; i < 4; i++) begin
        {a1, b1} = 2'(i);
        #1;
        check($sformatf("xor_ab%0d%0d", a1, b1), 64'(y1), 64'(xor_exp[i]));
        #9;
      end
    end

    // Op sweep over all operand pairs.
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 4; i++) begin
        logic [3:0] col;
        op1 = 3'(o);
        {a1, b1} = 2'(i);
        col = truth[o];
        #1;
        check($sformatf("op%0d_ab%0d%0d", o, a1, b1), 64'(y1), 64'(col[i]));
      end
    end

    // Register latency.
    op1 = 3'b000; a1 = 1'b0; b1 = 1'b0;
    tick();
    check("lat_pre_y_q", 64'(y1_q), 64'd0);
    a1 = 1'b1; b1 = 1'b0;
    #1;
    check("lat_y_immediate", 64'(y1), 64'd1);
    check("lat_y_q_holds", 64'(y1_q), 64'd0);
    check("lat_par_holds", 64'(y1_q_par), 64'd0);
    tick();
    check("lat_y_q_after_edge", 64'(y1_q), 64'd1);
    check("lat_par_after_edge", 64'(y1_q_par), 64'd1);

    // Mid-cycle glitch on inputs must not reach y_q.
    #2 a1 = 1'b0;
    #2 a1 = 1'b1;
    #1;
    check("glitch_y_q_stable", 64'(y1_q), 64'd1);

    // Mid-stream reset.
    rst = 1'b1;
    tick();
    check("rst_y_q_cleared", 64'(y1_q), 64'd0);
    check("rst_par_cleared", 64'(y1_q_par), 64'd0);
    check("rst_y_still_1", 64'(y1), 64'd1);
    rst = 1'b0;
    tick();
    check("rst_release_capture", 64'(y1_q), 64'd1);

    // op change: y immediately, y_q at next edge.
    op1 = 3'b001;
    #1;
    check("opchg_y", 64'(y1), 64'd0);
    check("opchg_y_q_holds", 64'(y1_q), 64'd1);
    tick();
    check("opchg_y_q", 64'(y1_q), 64'd0);

    // X on an operand propagates through y.
    op1 = 3'b000; a1 = 1'bx; b1 = 1'b0;
    #1;
    check("x_propagates", 64'(y1), 64'(1'bx));
    a1 = 1'b0;

    // 8-bit vectors.
    a8 = 8'hA5; b8 = 8'h0F; op8 = 3'b000;
    #1;
    check("w8_xor_y", 64'(y8), 64'h00AA);
    tick();
    check("w8_xor_y_q", 64'(y8_q), 64'h00AA);
    check("w8_xor_par", 64'(y8_q_par), 64'd0);
    op8 = 3'b001;
    #1;
    check("w8_and_y", 64'(y8), 64'h0005);
    op8 = 3'b010;
    #1;
    check("w8_or_y", 64'(y8), 64'h00AF);
    a8 = 8'h01; b8 = 8'h00; op8 = 3'b000;
    tick();
    check("w8_odd_y_q", 64'(y8_q), 64'h0001);
    check("w8_odd_par", 64'(y8_q_par), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_xor_gates
